// File: rtl/async_fifo_drain_if.sv
// Handshake bundle between the async FIFO read port, the drain stage and its consumer.
// The drain stage takes the master side; the consumer/FIFO model takes the slave side.
interface async_fifo_drain_if #(
  parameter int DW = 32
);
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  out_ready,
    output fifo_pop,
    output out_valid,
    output out_data
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output out_ready,
    input  fifo_pop,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/async_fifo_drain.sv
// Read-side drain for async_fifo: pops into a small prefetch ring, absorbs the FIFO's
// one-cycle read latency and presents words over valid/ready with a delivered-word count.
module async_fifo_drain #(
  parameter  int BUF_DEPTH = 4,
  parameter  int DW        = 32,
  localparam int AW        = $clog2(BUF_DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                 clk_rdd,
  input  logic                 rst,
  async_fifo_drain_if.master   bus,
  output logic [LW-1:0]        level_o,
  output logic [15:0]          word_cnt_o
);

  logic [DW-1:0] mem_q [BUF_DEPTH];
  logic [AW-1:0] rp_q, rp_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [LW-1:0] occ_q, occ_d;
  logic          inflight_q;
  logic [15:0]   cnt_q, cnt_d;

  logic [LW:0]   credit;
  logic          pop;
  logic          capture;
  logic          drain;

  // The pop credit counts the word already in flight and ignores a same-cycle drain,
  // so the ring can never be overrun.
  always_comb begin
    credit  = {1'b0, occ_q} + {{LW{1'b0}}, inflight_q};
    pop     = rst && !bus.fifo_empty && (credit < (LW+1)'(BUF_DEPTH));
    capture = inflight_q;
    drain   = (occ_q != '0) && bus.out_ready;
  end

  // Pointers wrap for free because BUF_DEPTH is a power of two.
  always_comb begin
    rp_d  = rp_q + AW'(drain);
    wp_d  = wp_q + AW'(capture);
    cnt_d = cnt_q + 16'(drain);
    occ_d = occ_q;
    case ({capture, drain})
      2'b10:   occ_d = occ_q + LW'(1);
      2'b01:   occ_d = occ_q - LW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_rdd) begin
    if (!rst) begin
      rp_q       <= '0;
      wp_q       <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rp_q       <= rp_d;
      wp_q       <= wp_d;
      occ_q      <= occ_d;
      inflight_q <= pop;
      cnt_q      <= cnt_d;
    end
  end

  // Storage is not reset; contents are only read where occ says they are valid.
  always_ff @(posedge clk_rdd) begin
    if (capture) begin
      mem_q[wp_q] <= bus.fifo_data;
    end
  end

  assign bus.fifo_pop  = pop;
  assign bus.out_valid = (occ_q != '0);
  assign bus.out_data  = mem_q[rp_q];
  assign level_o       = occ_q;
  assign word_cnt_o    = cnt_q;

endmodule

// File: tb/tb_async_fifo_drain.sv
// Bench for async_fifo_drain: a directed cycle table, then randomized traffic checked
// against a queue-based model of the FIFO source and the drain's delivery rules.
module tb_async_fifo_drain;
  localparam int D  = 4;
  localparam int DW = 32;

  logic        clk_rdd = 1'b0;
  logic        rst;
  logic [2:0]  level;
  logic [15:0] word_cnt;

  async_fifo_drain_if #(.DW(DW)) bus ();

  async_fifo_drain #(.BUF_DEPTH(D), .DW(DW)) dut (
    .clk_rdd    (clk_rdd),
    .rst        (rst),
    .bus        (bus),
    .level_o    (level),
    .word_cnt_o (word_cnt)
  );

  always #5 clk_rdd = ~clk_rdd;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        r;
    logic        e;
    logic        rdy;
    logic [31:0] fd;
    logic        pop;
    logic        v;
    int          lvl;
    logic [31:0] d;
    int          cnt;
  } vec_t;

  vec_t tbl[20];

  // Source FIFO and reference model state
  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  int          m_occ = 0;
  int          m_infl = 0;
  logic [15:0] m_cnt = 16'd0;
  int          pop_cnt = 0;
  int          dut_valid_cycles = 0;
  int          max_level = 0;
  bit          want_first = 1'b0;
  logic [31:0] first_word = 32'd0;

  task automatic mc(input logic r, input logic rdy, input logic hold);
    logic        exp_pop;
    logic        mv;
    logic        act_pop;
    logic        xfer;
    logic [31:0] cur;
    rst            = r;
    bus.out_ready  = rdy;
    bus.fifo_empty = hold || (src_q.size() == 0);
    cur            = bus.fifo_data;
    @(negedge clk_rdd);
    exp_pop = r && !bus.fifo_empty && (m_occ + m_infl < D);
    mv      = (m_occ != 0);
    chk("pop", bus.fifo_pop, exp_pop);
    chk("valid", bus.out_valid, mv);
    chk("level", level, m_occ);
    chk("word_cnt", word_cnt, m_cnt);
    if (mv && exp_q.size() > 0) chk("data", bus.out_data, exp_q[0]);
    if (bus.out_valid === 1'b1) dut_valid_cycles++;
    if (int'(level) > max_level) max_level = int'(level);
    act_pop = bus.fifo_pop;
    if (act_pop === 1'b1) pop_cnt++;
    xfer = mv && rdy && r;
    if (xfer) begin
      if (want_first) begin
        chk("first_after_rst", bus.out_data, first_word);
        want_first = 1'b0;
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(posedge clk_rdd);
    #1;
    if (!r) begin
      m_occ  = 0;
      m_infl = 0;
      m_cnt  = 16'd0;
      exp_q.delete();
    end else begin
      if (m_infl != 0) exp_q.push_back(cur);
      m_occ  = m_occ + m_infl - (xfer ? 1 : 0);
      if (xfer) m_cnt = m_cnt + 16'd1;
      m_infl = exp_pop ? 1 : 0;
    end
    if (act_pop === 1'b1 && src_q.size() > 0) bus.fifo_data = src_q.pop_front();
    else bus.fifo_data = $urandom();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            r     e     rdy   fd           pop   v     lvl d            cnt
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h0,      1'b0, 1'b0, 0, 32'h0,      0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h0,      1'b1, 1'b0, 0, 32'h0,      0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h1,      1'b0, 1'b0, 0, 32'h0,      0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h0,      1'b0, 1'b1, 1, 32'h1,      0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 0, 32'h0,      1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 0, 32'h0,      1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'hA0,     1'b1, 1'b0, 0, 32'h0,      1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'hA1,     1'b1, 1'b1, 1, 32'hA0,     1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'hA2,     1'b1, 1'b1, 2, 32'hA0,     1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'hA3,     1'b0, 1'b1, 3, 32'hA0,     1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 4, 32'hA0,     1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h0,      1'b0, 1'b1, 4, 32'hA0,     1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 32'h0,      1'b1, 1'b1, 3, 32'hA1,     2};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'hA4,     1'b1, 1'b1, 2, 32'hA2,     3};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 32'hA5,     1'b0, 1'b1, 3, 32'hA2,     3};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 32'h0,      1'b0, 1'b1, 4, 32'hA2,     3};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 32'h0,      1'b0, 1'b1, 3, 32'hA3,     4};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 32'h0,      1'b0, 1'b1, 2, 32'hA4,     5};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 32'h0,      1'b0, 1'b1, 1, 32'hA5,     6};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 32'h0,      1'b0, 1'b0, 0, 32'h0,      7};

    rst            = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    bus.out_ready  = 1'b0;
    repeat (2) @(posedge clk_rdd);
    #1;

    // Directed single word plus backpressure/wrap table
    for (int i = 0; i < 20; i++) begin
      rst            = tbl[i].r;
      bus.fifo_empty = tbl[i].e;
      bus.out_ready  = tbl[i].rdy;
      bus.fifo_data  = tbl[i].fd;
      @(negedge clk_rdd);
      chk($sformatf("tbl%0d_pop", i), bus.fifo_pop, tbl[i].pop);
      chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].v);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("tbl%0d_cnt", i), word_cnt, tbl[i].cnt);
      if (tbl[i].v) chk($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].d);
      @(posedge clk_rdd);
      #1;
    end
    m_cnt = 16'd7;

    // Streaming 1..15 with an always-ready consumer
    mc(1'b0, 1'b1, 1'b0);
    for (int w = 1; w <= 15; w++) src_q.push_back(32'(w));
    dut_valid_cycles = 0;
    max_level = 0;
    repeat (18) mc(1'b1, 1'b1, 1'b0);
    chk("stream_valid_cycles", 32'(dut_valid_cycles), 32'd15);
    chk("stream_level_le2", 32'(max_level <= 2), 32'd1);
    chk("stream_cnt", word_cnt, 16'd15);

    // Backpressure: 8 words, consumer stalled, then released
    mc(1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 8; w++) src_q.push_back(32'h100 + 32'(w));
    pop_cnt = 0;
    repeat (10) mc(1'b1, 1'b0, 1'b0);
    chk("bp_pops", 32'(pop_cnt), 32'd4);
    chk("bp_level", level, 3'd4);
    chk("bp_head", bus.out_data, 32'h100);
    repeat (14) mc(1'b1, 1'b1, 1'b0);
    chk("bp_cnt", word_cnt, 16'd8);

    // Alternating ready across 20 words
    mc(1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 20; w++) src_q.push_back(32'h200 + 32'(w));
    for (int c = 0; c < 60; c++) mc(1'b1, c[0], 1'b0);
    chk("alt_cnt", word_cnt, 16'd20);

    // Randomized traffic with occasional FIFO empties and resets
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 2) != 0) src_q.push_back($urandom());
      mc(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    // Reset with level 3 and a word in flight
    mc(1'b0, 1'b0, 1'b0);
    src_q.delete();
    for (int w = 0; w < 10; w++) src_q.push_back(32'h300 + 32'(w));
    begin
      bit reached = 1'b0;
      for (int c = 0; c < 20 && !reached; c++) begin
        if (m_occ == 3 && m_infl == 1) reached = 1'b1;
        else mc(1'b1, 1'b0, 1'b0);
      end
      chk("rst_setup_reached", 32'(reached), 32'd1);
    end
    mc(1'b0, 1'b0, 1'b0);
    mc(1'b0, 1'b0, 1'b0);
    want_first = 1'b1;
    first_word = src_q[0];
    repeat (12) mc(1'b1, 1'b1, 1'b0);
    chk("rst_first_seen", 32'(want_first), 32'd0);

    // word_cnt wrap after 65537 deliveries
    mc(1'b0, 1'b0, 1'b0);
    src_q.delete();
    begin
      int pushed = 0;
      for (int c = 0; c < 65537 + 6; c++) begin
        if (pushed < 65537 && src_q.size() < 4) begin
          src_q.push_back(32'(pushed));
          pushed++;
        end
        mc(1'b1, 1'b1, 1'b0);
      end
    end
    chk("wrap_cnt", word_cnt, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_drain.md
# async_fifo_drain

Read-side drain stage placed directly downstream of `async_fifo`, in the `clk_rdd` domain. It issues `pop` to the FIFO whenever data is available and local space is guaranteed, absorbs the FIFO's one-cycle read latency, and presents words to the consumer over a valid/ready handshake. Its prefetch buffer sustains one word per cycle when the consumer is always ready. It also reports buffer level and a delivered-word count.

## Interface
- `BUF_DEPTH`, default 4: prefetch buffer entries; power of 2, ≥ 2; full throughput requires ≥ 4.
- `DW`, default 32: data width, matches `async_fifo` data width.
- `clk_rdd`  in  1: read-domain clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `fifo_empty`  in  1: `empty` from `async_fifo`.
- `fifo_data`  in  DW: `data_out` from `async_fifo`; valid the cycle after a pop is sampled.
- `fifo_pop`  out  1: `pop` to `async_fifo`; combinational from registered state and `fifo_empty`.
- `out_valid`  out  1: buffered word available.
- `out_data`  out  DW: head word of the buffer.
- `out_ready`  in  1: consumer accepts the word this cycle.
- `level`  out  $clog2(BUF_DEPTH)+1: current buffer occupancy.
- `word_cnt`  out  16: count of words delivered to the consumer.

## Operation
- State: circular buffer of BUF_DEPTH×DW, read pointer `rp`, write pointer `wp`, occupancy `occ`, one-bit `inflight`, and `word_cnt`.
- Pop rule: `fifo_pop = rst && !fifo_empty && (occ + inflight < BUF_DEPTH)`.
  - Uses registered `occ`.
  - Does not credit a same-cycle drain, so it is conservative.
  - Overflow is therefore impossible.
- `inflight` is registered from `fifo_pop`.
- Capture: in any cycle with `inflight == 1`, write `fifo_data` to `buf[wp]` and advance `wp`, wrapping modulo BUF_DEPTH.
- Drain: `out_valid = (occ != 0)` and `out_data = buf[rp]`. When `out_valid && out_ready`:
  - advance `rp`, wrapping modulo BUF_DEPTH;
  - increment `word_cnt`, wrapping 16'hFFFF → 0.
- Occupancy update:
  - capture and drain in the same cycle: `occ` unchanged;
  - capture only: +1;
  - drain only: −1.
- `out_ready` while `out_valid == 0` has no effect.
- `level = occ`.
- Words are delivered in exact pop order, with no duplication or loss.
- Handshake: while `out_valid && !out_ready`, `out_valid` and `out_data` hold stable. `out_valid` never drops without a transfer.
- Reset: at a clock edge with `rst == 0`:
  - `occ`, `rp`, `wp`, `inflight` and `word_cnt` clear to 0;
  - outputs become `out_valid=0`, `level=0`, `word_cnt=0`;
  - `fifo_pop` is held 0 combinationally for the whole reset period;
  - a word in flight at reset is discarded, and buffer contents are don't-care.
- Reset mid-stream: words buffered at reset are lost. The first valid after release is the next word popped after release.

## Timing
- Pop sampled at edge E0. `fifo_data` is valid in cycle E0..E1 and captured at edge E1. `out_valid` rises after E1, so the word is transferable in cycle E1..E2.
- First-word latency: `fifo_empty` falls in cycle C, `fifo_pop` rises in cycle C, and `out_valid` rises in cycle C+2.
- Steady state with `out_ready=1` and FIFO never empty: one word per cycle, with `occ` settling at 1 and `inflight`=1.
- Backpressure with `out_ready=0`: pops stop once `occ + inflight == BUF_DEPTH`. `occ` reaches BUF_DEPTH one cycle later.
- Release of backpressure: a pop resumes the cycle after the first drain lowers `occ` below the limit.
- Wrap-around of `rp`/`wp` at BUF_DEPTH−1 → 0 adds no bubble.
- `fifo_empty` rising with `inflight=1`: that word is still captured. No further pops are issued.

## Test plan
- **Single word.** After reset, FIFO holds 0x1, `out_ready=1`. Expect: one `fifo_pop` pulse; `out_valid` 2 cycles later with `out_data=0x1`; `word_cnt=1`; then `out_valid=0`, `level=0`.
- **Streaming.** FIFO preloaded with 1..15, `out_ready=1`. Expect: after the first word, 1..15 delivered on consecutive cycles in order; `word_cnt=15`; `level` never exceeds 2.
- **Backpressure.** `out_ready=0` with 8 words available, BUF_DEPTH=4. Expect: exactly 4 pops; `level=4`; `out_data` held at the first word. Then `out_ready=1`: all 8 words delivered in order, with no pop while `occ + inflight == 4`.
- **Alternating ready.** `out_ready` toggles every cycle across 20 words. Expect: no loss or duplication; `out_data` stable whenever stalled; pointers wrap correctly.
- **Reset mid-operation.** Assert `rst=0` for 2 cycles with `level=3` and `inflight=1`. Expect:
  - next edge: `out_valid=0`, `level=0`, `word_cnt=0`;
  - `fifo_pop=0` throughout reset;
  - after release, the next FIFO word is the first delivered.
- **Counter wrap.** Deliver 65537 words. Expect: `word_cnt=1`.
